// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and widths for the memory pipeline stage
package mem_pkg;

    localparam int DATA_W         = 32;
    localparam int REG_W          = 4;
    localparam int CNT_W          = 4;
    localparam int WAIT_LIMIT_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } mem_state_t;

endpackage

// File: rtl/flopenrc.sv
// rtl/flopenrc.sv - enabled register with synchronous clear and async active-low reset
module flopenrc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // clear only takes effect on an enabled edge, so a held register ignores it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= clear ? '0 : d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage with E/M and M/W registers and bus wait/timeout FSM
module mem_stage
    import mem_pkg::*;
#(
    parameter int WAIT_LIMIT = WAIT_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              PCSrcE,
    input  logic              RegWriteE,
    input  logic              MemtoRegE,
    input  logic              MemWriteE,
    input  logic [REG_W-1:0]  RdE,
    input  logic [DATA_W-1:0] ALUResultE,
    input  logic [DATA_W-1:0] WriteDataE,
    output logic [DATA_W-1:0] DataAdr,
    output logic [DATA_W-1:0] WriteDataMem,
    output logic              MemReq,
    output logic              MemWe,
    input  logic              MemReady,
    input  logic [DATA_W-1:0] ReadData,
    output logic [DATA_W-1:0] ALUResultM,
    output logic [REG_W-1:0]  RdM,
    output logic              RegWriteM,
    output logic              StallM,
    output logic              BusError,
    output logic              PCSrcW,
    output logic              RegWriteW,
    output logic              MemtoRegW,
    output logic [REG_W-1:0]  RdW,
    output logic [DATA_W-1:0] ALUOutW,
    output logic [DATA_W-1:0] ReadDataW
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

    mem_state_t        state, state_next;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_next;
    logic              PCSrcM, MemtoRegM, MemWriteM;
    logic [DATA_W-1:0] WriteDataM;
    logic              memop;
    logic              adv;
    logic              mw_bubble;

    assign adv       = ~StallM;
    // a stalled or timed-out access leaves a bubble behind it in writeback
    assign mw_bubble = StallM | (state == ST_ERR);

    flopenrc #(.WIDTH(4)) u_em_ctrl (
        .clk   (clk),
        .reset (reset),
        .en    (adv),
        .clear (flush),
        .d     ({PCSrcE, RegWriteE, MemtoRegE, MemWriteE}),
        .q     ({PCSrcM, RegWriteM, MemtoRegM, MemWriteM})
    );

    flopenrc #(.WIDTH(REG_W + 2 * DATA_W)) u_em_data (
        .clk   (clk),
        .reset (reset),
        .en    (adv),
        .clear (1'b0),
        .d     ({RdE, ALUResultE, WriteDataE}),
        .q     ({RdM, ALUResultM, WriteDataM})
    );

    flopenrc #(.WIDTH(3)) u_mw_ctrl (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .clear (mw_bubble),
        .d     ({PCSrcM, RegWriteM, MemtoRegM}),
        .q     ({PCSrcW, RegWriteW, MemtoRegW})
    );

    flopenrc #(.WIDTH(REG_W + 2 * DATA_W)) u_mw_data (
        .clk   (clk),
        .reset (reset),
        .en    (adv),
        .clear (1'b0),
        .d     ({RdM, ALUResultM, ReadData}),
        .q     ({RdW, ALUOutW, ReadDataW})
    );

    assign memop        = MemWriteM | MemtoRegM;
    assign MemReq       = memop & (state != ST_ERR);
    assign MemWe        = MemWriteM & MemReq;
    assign StallM       = MemReq & ~MemReady;
    assign DataAdr      = ALUResultM;
    assign WriteDataMem = WriteDataM;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            BusError <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (state_next == ST_ERR) begin
                BusError <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            ST_IDLE: begin
                wait_cnt_next = '0;
                if (memop && !MemReady) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!memop || MemReady) begin
                    state_next = ST_IDLE;
                end else if (wait_cnt == LIMIT) begin
                    state_next = ST_ERR;
                end
                // saturate so a large limit can never wrap the count
                if (wait_cnt != '1) begin
                    wait_cnt_next = wait_cnt + 4'd1;
                end
            end
            ST_ERR: begin
                state_next    = ST_IDLE;
                wait_cnt_next = '0;
            end
            default: begin
                state_next    = ST_IDLE;
                wait_cnt_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage against a transaction-level model
module tb_mem_stage;

    localparam int LIMIT = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush, PCSrcE, RegWriteE, MemtoRegE, MemWriteE;
    logic [3:0]  RdE;
    logic [31:0] ALUResultE, WriteDataE;
    logic [31:0] DataAdr, WriteDataMem;
    logic        MemReq, MemWe, MemReady;
    logic [31:0] ReadData;
    logic [31:0] ALUResultM;
    logic [3:0]  RdM;
    logic        RegWriteM, StallM, BusError;
    logic        PCSrcW, RegWriteW, MemtoRegW;
    logic [3:0]  RdW;
    logic [31:0] ALUOutW, ReadDataW;

    always #5 clk = ~clk;

    mem_stage #(.WAIT_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .RdE(RdE), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
        .DataAdr(DataAdr), .WriteDataMem(WriteDataMem), .MemReq(MemReq), .MemWe(MemWe),
        .MemReady(MemReady), .ReadData(ReadData),
        .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM), .StallM(StallM), .BusError(BusError),
        .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .RdW(RdW),
        .ALUOutW(ALUOutW), .ReadDataW(ReadDataW)
    );

    typedef struct packed {
        logic        pcsrc, regw, memtoreg, memw;
        logic [3:0]  rd;
        logic [31:0] alu, wd;
    } em_t;

    typedef struct packed {
        logic        pcsrc, regw, memtoreg;
        logic [3:0]  rd;
        logic [31:0] aluout, rdata;
    } wb_t;

    // Model: an access stalls until MemReady; after LIMIT+2 consecutive stalled
    // cycles (request cycle plus wait counts 0..LIMIT) it is abandoned for one cycle.
    em_t  m_em;
    wb_t  m_wb;
    int   m_stalled;
    logic m_err, m_buserr;
    logic exp_req, exp_stall, exp_we;

    always_comb begin
        exp_req   = (m_em.memw | m_em.memtoreg) & ~m_err;
        exp_stall = exp_req & ~MemReady;
        exp_we    = m_em.memw & exp_req;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_em      <= '0;
            m_wb      <= '0;
            m_stalled <= 0;
            m_err     <= 1'b0;
            m_buserr  <= 1'b0;
        end else begin
            if (!exp_stall) begin
                m_em.pcsrc    <= PCSrcE & ~flush;
                m_em.regw     <= RegWriteE & ~flush;
                m_em.memtoreg <= MemtoRegE & ~flush;
                m_em.memw     <= MemWriteE & ~flush;
                m_em.rd       <= RdE;
                m_em.alu      <= ALUResultE;
                m_em.wd       <= WriteDataE;
                m_wb.rd       <= m_em.rd;
                m_wb.aluout   <= m_em.alu;
                m_wb.rdata    <= ReadData;
            end
            if (exp_stall || m_err) begin
                m_wb.pcsrc    <= 1'b0;
                m_wb.regw     <= 1'b0;
                m_wb.memtoreg <= 1'b0;
            end else begin
                m_wb.pcsrc    <= m_em.pcsrc;
                m_wb.regw     <= m_em.regw;
                m_wb.memtoreg <= m_em.memtoreg;
            end
            if (exp_stall) begin
                m_stalled <= m_stalled + 1;
                if (m_stalled + 1 == LIMIT + 2) begin
                    m_err    <= 1'b1;
                    m_buserr <= 1'b1;
                end
            end else begin
                m_stalled <= 0;
                m_err     <= 1'b0;
            end
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    int stall_seen = 0;
    int we_seen = 0;
    int s0, w0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk1("MemReq", MemReq, exp_req);
        chk1("StallM", StallM, exp_stall);
        chk1("MemWe", MemWe, exp_we);
        chk("DataAdr", DataAdr, m_em.alu);
        chk("WriteDataMem", WriteDataMem, m_em.wd);
        chk("ALUResultM", ALUResultM, m_em.alu);
        chk("RdM", 32'(RdM), 32'(m_em.rd));
        chk1("RegWriteM", RegWriteM, m_em.regw);
        chk1("BusError", BusError, m_buserr);
        chk1("PCSrcW", PCSrcW, m_wb.pcsrc);
        chk1("RegWriteW", RegWriteW, m_wb.regw);
        chk1("MemtoRegW", MemtoRegW, m_wb.memtoreg);
        chk("RdW", 32'(RdW), 32'(m_wb.rd));
        chk("ALUOutW", ALUOutW, m_wb.aluout);
        chk("ReadDataW", ReadDataW, m_wb.rdata);
    endtask

    task automatic cycle(input logic rdy, input logic [31:0] rdata);
        MemReady = rdy;
        ReadData = rdata;
        @(negedge clk);
        compare_all();
        if (StallM) stall_seen++;
        if (MemWe) we_seen++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_e(input logic pcsrc, input logic regw, input logic memtoreg, input logic memw,
                         input logic [3:0] rd, input logic [31:0] alu, input logic [31:0] wd,
                         input logic fl);
        PCSrcE = pcsrc; RegWriteE = regw; MemtoRegE = memtoreg; MemWriteE = memw;
        RdE = rd; ALUResultE = alu; WriteDataE = wd; flush = fl;
    endtask

    task automatic nop();
        set_e(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        nop();
        MemReady = 1'b0;
        ReadData = 32'h0;
        #12;
        chk1("reset MemReq", MemReq, 1'b0);
        chk1("reset StallM", StallM, 1'b0);
        chk1("reset BusError", BusError, 1'b0);
        chk1("reset RegWriteW", RegWriteW, 1'b0);
        chk("reset ALUResultM", ALUResultM, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // plain ALU op; MemReady pulses are irrelevant without a memory op
        set_e(1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 32'h0000_1234, 32'h0, 1'b0);
        cycle(1'b0, 32'h0);
        nop();
        chk1("alu RegWriteM", RegWriteM, 1'b1);
        chk("alu RdM", 32'(RdM), 32'd7);
        chk("alu ALUResultM", ALUResultM, 32'h0000_1234);
        chk1("alu MemReq", MemReq, 1'b0);
        cycle(1'b1, 32'h0000_FFFF);
        chk1("alu RegWriteW", RegWriteW, 1'b1);
        chk1("alu PCSrcW", PCSrcW, 1'b1);
        chk("alu ALUOutW", ALUOutW, 32'h0000_1234);

        // zero-wait load
        set_e(1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 32'h0000_0100, 32'h0, 1'b0);
        cycle(1'b0, 32'h0);
        nop();
        s0 = stall_seen;
        chk1("ldr MemReq", MemReq, 1'b1);
        chk("ldr DataAdr", DataAdr, 32'h0000_0100);
        cycle(1'b1, 32'hDEAD_BEEF);
        chk("ldr stalls", 32'(stall_seen - s0), 32'd0);
        chk("ldr ReadDataW", ReadDataW, 32'hDEAD_BEEF);
        chk1("ldr MemtoRegW", MemtoRegW, 1'b1);
        chk("ldr RdW", 32'(RdW), 32'd3);

        // 3-wait store; a flush presented while stalled must be ignored
        set_e(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'h0000_0200, 32'h5A5A_5A5A, 1'b0);
        cycle(1'b0, 32'h0);
        set_e(1'b0, 1'b1, 1'b0, 1'b0, 4'd9, 32'h0000_0999, 32'h0, 1'b1);
        s0 = stall_seen;
        w0 = we_seen;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0);
            chk("str DataAdr held", DataAdr, 32'h0000_0200);
            chk("str WriteDataMem held", WriteDataMem, 32'h5A5A_5A5A);
            chk1("str MemWe held", MemWe, 1'b1);
            chk1("str RegWriteW bubble", RegWriteW, 1'b0);
        end
        set_e(1'b0, 1'b1, 1'b0, 1'b0, 4'd9, 32'h0000_0999, 32'h0, 1'b0);
        cycle(1'b1, 32'h0);
        chk("str stall cycles", 32'(stall_seen - s0), 32'd3);
        chk("str MemWe cycles", 32'(we_seen - w0), 32'd4);
        chk1("str next RegWriteM", RegWriteM, 1'b1);
        chk("str next RdM", 32'(RdM), 32'd9);
        nop();
        cycle(1'b0, 32'h0);
        chk1("post-str RegWriteW", RegWriteW, 1'b1);
        chk("post-str RdW", 32'(RdW), 32'd9);

        // timeout: request cycle plus 16 wait cycles, then one error cycle
        set_e(1'b0, 1'b1, 1'b1, 1'b0, 4'd4, 32'h0000_0300, 32'h0, 1'b0);
        cycle(1'b0, 32'h0);
        nop();
        s0 = stall_seen;
        repeat (LIMIT + 2) cycle(1'b0, 32'h0);
        chk("tmo stall cycles", 32'(stall_seen - s0), 32'd17);
        chk1("tmo BusError", BusError, 1'b1);
        chk1("tmo MemReq", MemReq, 1'b0);
        chk1("tmo StallM", StallM, 1'b0);
        cycle(1'b0, 32'h0);
        chk1("tmo retire RegWriteW", RegWriteW, 1'b0);
        chk1("tmo BusError after", BusError, 1'b1);
        repeat (3) cycle(1'b1, 32'h0);
        chk1("tmo BusError sticky", BusError, 1'b1);

        // flush bubbles an ALU op
        set_e(1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 32'h0000_0055, 32'h0, 1'b1);
        cycle(1'b0, 32'h0);
        chk1("flush RegWriteM", RegWriteM, 1'b0);
        nop();
        cycle(1'b0, 32'h0);
        chk1("flush RegWriteW", RegWriteW, 1'b0);

        // reset asserted during the second wait cycle
        set_e(1'b0, 1'b1, 1'b1, 1'b0, 4'd6, 32'h0000_0400, 32'h0, 1'b0);
        cycle(1'b0, 32'h0);
        nop();
        cycle(1'b0, 32'h0);
        cycle(1'b0, 32'h0);
        chk1("rst pre StallM", StallM, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk1("rst MemReq", MemReq, 1'b0);
        chk1("rst StallM", StallM, 1'b0);
        chk1("rst MemWe", MemWe, 1'b0);
        chk1("rst BusError", BusError, 1'b0);
        chk("rst DataAdr", DataAdr, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        set_e(1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 32'h0000_0ABC, 32'h0, 1'b0);
        cycle(1'b0, 32'h0);
        chk1("resume RegWriteM", RegWriteM, 1'b1);
        chk("resume ALUResultM", ALUResultM, 32'h0000_0ABC);
        // zero-wait load right after reset proves the FSM restarted idle
        set_e(1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 32'h0000_0500, 32'h0, 1'b0);
        cycle(1'b0, 32'h0);
        nop();
        s0 = stall_seen;
        cycle(1'b1, 32'h1234_5678);
        chk("resume ldr stalls", 32'(stall_seen - s0), 32'd0);
        chk("resume ReadDataW", ReadDataW, 32'h1234_5678);
        cycle(1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
